// File: rtl/sgd_linreg_trainer.sv
// sgd_linreg_trainer: fixed-point SGD trainer for y_hat = W0 + sum(Wi*Xi).
// Samples (F features + target) live in an internal RAM loaded via wr_*.
// start runs `epochs` passes over samples 0..DP-1 with one shared multiplier.
// Build option: define SGD_SATURATE_EN to saturate mul/acc/error/weight math.
// Ports:
//   CLK, RST           clock, async active-high reset
//   wr_en/sample/col/data  sample RAM write port (ignored while busy)
//   start, init_w, epochs  training request (sampled in IDLE)
//   busy, done             status (done is a one-cycle pulse)
//   w_rd_addr, w_rd_data   combinational weight read, 0 when addr > F
//   err_out                error of the most recent sample
module sgd_linreg_trainer #(
  parameter int unsigned BITS     = 16,
  parameter int unsigned FRAC     = 8,
  parameter int unsigned F        = 4,
  parameter int unsigned DP       = 4,
  parameter int unsigned LR_SHIFT = 7,
  parameter logic [BITS-1:0] W_INIT = BITS'(16'h0040),
  parameter int unsigned EP_W     = 8,
  localparam int unsigned SW      = (DP > 1) ? $clog2(DP) : 1,
  localparam int unsigned CW      = $clog2(F + 1)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            wr_en,
  input  logic [SW-1:0]   wr_sample,
  input  logic [CW-1:0]   wr_col,
  input  logic [BITS-1:0] wr_data,
  input  logic            start,
  input  logic            init_w,
  input  logic [EP_W-1:0] epochs,
  output logic            busy,
  output logic            done,
  input  logic [CW-1:0]   w_rd_addr,
  output logic [BITS-1:0] w_rd_data,
  output logic [BITS-1:0] err_out
);

  localparam int unsigned PW = 2 * BITS;
`ifdef SGD_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PRED, S_ERR, S_UPD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     smp_q, smp_d;
  logic [EP_W-1:0]   ep_q, ep_d;
  logic [EP_W-1:0]   ep_tgt_q, ep_tgt_d;
  logic [BITS-1:0]   acc_q, acc_d;
  logic [BITS-1:0]   g_q, g_d;
  logic [BITS-1:0]   err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BITS-1:0]   w_q [F+1];
  logic [BITS-1:0]   w_d [F+1];
  logic [BITS-1:0]   mem_q [DP][F+1];

  logic [CW-1:0]     col;
  logic [BITS-1:0]   x_sel, mul_a, mul_r, e_c;
  logic [PW-1:0]     prod, prod_sh;

  // Sign-extend a word to the double-width working precision.
  function automatic logic [PW-1:0] sx(input logic [BITS-1:0] v);
    return {{BITS{v[BITS-1]}}, v};
  endfunction

  // Reduce a double-width result to BITS: wrap, or clamp when saturation is built in.
  function automatic logic [BITS-1:0] fit(input logic [PW-1:0] v);
    logic ovf;
    ovf = (v[PW-1:BITS-1] != {(PW-BITS+1){v[PW-1]}});
    if (SAT_EN && ovf) return v[PW-1] ? {1'b1, {(BITS-1){1'b0}}} : {1'b0, {(BITS-1){1'b1}}};
    return v[BITS-1:0];
  endfunction

  // Shared multiplier: PRED uses X[idx]*W[idx+1], UPD uses g*X[idx-1].
  always_comb begin
    col     = (state_q == S_UPD && idx_q != '0) ? idx_q - CW'(1) : idx_q;
    x_sel   = mem_q[smp_q][col];
    mul_a   = (state_q == S_UPD) ? g_q : w_q[idx_q + CW'(1)];
    prod    = sx(mul_a) * sx(x_sel);
    prod_sh = $signed(prod) >>> FRAC;
    mul_r   = fit(prod_sh);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    smp_d    = smp_q;
    ep_d     = ep_q;
    ep_tgt_d = ep_tgt_q;
    acc_d    = acc_q;
    g_d      = g_q;
    err_d    = err_q;
    w_d      = w_q;
    e_c      = fit(sx(mem_q[smp_q][CW'(F)]) - sx(acc_q));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ep_tgt_d = epochs;
          ep_d     = '0;
          smp_d    = '0;
          idx_d    = '0;
          if (init_w) w_d = '{default: W_INIT};
          acc_d    = init_w ? W_INIT : w_q[0];
          state_d  = (epochs == '0) ? S_DONE : S_PRED;
        end
      end
      S_PRED: begin
        acc_d = fit(sx(acc_q) + sx(mul_r));
        if (idx_q == CW'(F - 1)) begin
          idx_d   = '0;
          state_d = S_ERR;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_ERR: begin
        err_d   = e_c;
        g_d     = $signed(e_c) >>> LR_SHIFT;
        idx_d   = '0;
        state_d = S_UPD;
      end
      S_UPD: begin
        if (idx_q == '0) w_d[0]     = fit(sx(w_q[0]) + sx(g_q));
        else             w_d[idx_q] = fit(sx(w_q[idx_q]) + sx(mul_r));
        if (idx_q == CW'(F)) begin
          idx_d = '0;
          // W0 was already refreshed at index 0, so it seeds the next prediction.
          acc_d = w_q[0];
          if (smp_q == SW'(DP - 1)) begin
            smp_d   = '0;
            ep_d    = ep_q + EP_W'(1);
            state_d = (ep_d == ep_tgt_q) ? S_DONE : S_PRED;
          end else begin
            smp_d   = smp_q + SW'(1);
            state_d = S_PRED;
          end
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_PRED) || (state_d == S_ERR) || (state_d == S_UPD);
    done_d = (state_d == S_DONE);
  end

  // Control and weight registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      smp_q    <= '0;
      ep_q     <= '0;
      ep_tgt_q <= '0;
      acc_q    <= '0;
      g_q      <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      w_q      <= '{default: W_INIT};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      smp_q    <= smp_d;
      ep_q     <= ep_d;
      ep_tgt_q <= ep_tgt_d;
      acc_q    <= acc_d;
      g_q      <= g_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      w_q      <= w_d;
    end
  end

  // Sample RAM: not reset, frozen while training.
  always_ff @(posedge CLK) begin
    if (wr_en && !busy_q && wr_col <= CW'(F)) mem_q[wr_sample][wr_col] <= wr_data;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_out   = err_q;
  assign w_rd_data = (w_rd_addr <= CW'(F)) ? w_q[w_rd_addr] : '0;

endmodule

// File: tb/tb_sgd_linreg_trainer.sv
// Bench for sgd_linreg_trainer: three instances (DP=1, DP=4, DP=1 with large W_INIT).
module tb_sgd_linreg_trainer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  wr_en = '0;
  logic [2:0]  start = '0;
  logic [1:0]  wr_sample = '0;
  logic [2:0]  wr_col = '0;
  logic [15:0] wr_data = '0;
  logic        init_w = 1'b0;
  logic [7:0]  epochs = '0;
  logic [2:0]  w_rd_addr = '0;
  logic [2:0]  busy_v, done_v;
  logic [15:0] err_v [3];
  logic [15:0] wrd_v [3];

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string           tag;
    logic [15:0]     err;
    logic [4:0][15:0] w;
  } exp_t;
  exp_t sb[$];

  logic [4:0][15:0] smp [4];

  always #5 clk = ~clk;

  sgd_linreg_trainer #(.DP(1)) u_a (
    .CLK(clk), .RST(rst), .wr_en(wr_en[0]), .wr_sample(wr_sample[0:0]), .wr_col(wr_col),
    .wr_data(wr_data), .start(start[0]), .init_w(init_w), .epochs(epochs),
    .busy(busy_v[0]), .done(done_v[0]), .w_rd_addr(w_rd_addr), .w_rd_data(wrd_v[0]),
    .err_out(err_v[0]));

  sgd_linreg_trainer #(.DP(4)) u_b (
    .CLK(clk), .RST(rst), .wr_en(wr_en[1]), .wr_sample(wr_sample), .wr_col(wr_col),
    .wr_data(wr_data), .start(start[1]), .init_w(init_w), .epochs(epochs),
    .busy(busy_v[1]), .done(done_v[1]), .w_rd_addr(w_rd_addr), .w_rd_data(wrd_v[1]),
    .err_out(err_v[1]));

  sgd_linreg_trainer #(.DP(1), .W_INIT(16'h7F00)) u_c (
    .CLK(clk), .RST(rst), .wr_en(wr_en[2]), .wr_sample(wr_sample[0:0]), .wr_col(wr_col),
    .wr_data(wr_data), .start(start[2]), .init_w(init_w), .epochs(epochs),
    .busy(busy_v[2]), .done(done_v[2]), .w_rd_addr(w_rd_addr), .w_rd_data(wrd_v[2]),
    .err_out(err_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [15:0] e, input logic [15:0] w0,
                              input logic [15:0] w1, input logic [15:0] w2,
                              input logic [15:0] w3, input logic [15:0] w4);
    exp_t r;
    r.tag = tag;
    r.err = e;
    r.w   = {w4, w3, w2, w1, w0};
    return r;
  endfunction

  function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b});
    p = p >>> 8;
    return p[15:0];
  endfunction

  // Reference SGD over the four DP=4 samples, W_INIT=0x0040, lr=2^-7.
  function automatic exp_t model(input string tag, input int n_ep);
    logic [15:0] w [5];
    logic [15:0] acc, e, g;
    for (int i = 0; i < 5; i++) w[i] = 16'h0040;
    e = '0;
    for (int ep = 0; ep < n_ep; ep++) begin
      for (int s = 0; s < 4; s++) begin
        acc = w[0];
        for (int i = 0; i < 4; i++) acc = acc + m_mul(smp[s][i], w[i+1]);
        e = smp[s][4] - acc;
        g = 16'($signed(e) >>> 7);
        w[0] = w[0] + g;
        for (int i = 1; i < 5; i++) w[i] = w[i] + m_mul(g, smp[s][i-1]);
      end
    end
    return mk(tag, e, w[0], w[1], w[2], w[3], w[4]);
  endfunction

  task automatic wr(input int k, input int s, input int c, input logic [15:0] d);
    @(negedge clk);
    wr_en[k]  = 1'b1;
    wr_sample = 2'(s);
    wr_col    = 3'(c);
    wr_data   = d;
    @(negedge clk);
    wr_en[k]  = 1'b0;
  endtask

  task automatic load(input int k, input int s, input logic [4:0][15:0] row);
    for (int c = 0; c < 5; c++) wr(k, s, c, row[c]);
  endtask

  // Start a run, count busy cycles and the cycle of the done pulse (bounded wait).
  task automatic run(input string tag, input int k, input logic [7:0] ep, input bit iw,
                     input bit interfere, input int exp_busy, input int exp_done);
    int bc, da;
    @(negedge clk);
    epochs   = ep;
    init_w   = iw;
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    bc = 0;
    da = -1;
    for (int c = 1; c <= 2000 && da < 0; c++) begin
      if (done_v[k]) da = c;
      else if (busy_v[k]) bc++;
      if (da < 0) begin
        if (interfere && c == 20) begin
          wr_en[k] = 1'b1; wr_sample = '0; wr_col = '0; wr_data = 16'h7000; start[k] = 1'b1;
        end else if (interfere && c == 21) begin
          wr_en[k] = 1'b0; start[k] = 1'b0;
        end
        @(negedge clk);
      end
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    check({tag, "_done_cycle"}, 32'(da), 32'(exp_done));
    @(negedge clk);
    check({tag, "_done_pulse_end"}, 32'(done_v[k]), 32'd0);
    check({tag, "_idle_after"}, 32'(busy_v[k]), 32'd0);
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    e = sb.pop_front();
    check({e.tag, "_err_out"}, 32'(err_v[k]), 32'(e.err));
    for (int i = 0; i < 5; i++) begin
      w_rd_addr = 3'(i);
      #1;
      check($sformatf("%s_w%0d", e.tag, i), 32'(wrd_v[k]), 32'(e.w[i]));
    end
    w_rd_addr = 3'd5;
    #1;
    check({e.tag, "_w_oob"}, 32'(wrd_v[k]), 32'd0);
  endtask

  initial begin
    int nd;
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) smp[s][c] = 16'(48 + 40 * s + 24 * c);
      smp[s][4] = 16'(256 + 80 * s);
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy_v), 32'd0);
    check("rst_done", 32'(done_v), 32'd0);
    check("rst_err_a", 32'(err_v[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      w_rd_addr = 3'(i);
      #1;
      check($sformatf("rst_wa%0d", i), 32'(wrd_v[0]), 32'h0040);
      check($sformatf("rst_wc%0d", i), 32'(wrd_v[2]), 32'h7F00);
    end

    // Zero features: only the bias learns.
    load(0, 0, {16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    sb.push_back(mk("v1", 16'h00C0, 16'h0041, 16'h0040, 16'h0040, 16'h0040, 16'h0040));
    run("v1", 0, 8'd1, 1'b1, 1'b0, 10, 11);
    pop_check(0);

    // Over-prediction: g = -1 pulls every weight down by one LSB.
    load(0, 0, {16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100});
    sb.push_back(mk("v2", 16'hFFC0, 16'h003F, 16'h003F, 16'h003F, 16'h003F, 16'h003F));
    run("v2", 0, 8'd1, 1'b1, 1'b0, 10, 11);
    pop_check(0);

    // Zero epochs: immediate done, weights and error untouched.
    sb.push_back(mk("ep0", 16'hFFC0, 16'h003F, 16'h003F, 16'h003F, 16'h003F, 16'h003F));
    run("ep0", 0, 8'd0, 1'b0, 1'b0, 0, 1);
    pop_check(0);

    // Reset in the middle of prediction aborts without a done pulse.
    load(0, 0, {16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
    @(negedge clk);
    epochs = 8'd5; init_w = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    check("abort_busy_before", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      w_rd_addr = 3'(i);
      #1;
      check($sformatf("abort_w%0d", i), 32'(wrd_v[0]), 32'h0040);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) nd++;
    end
    check("abort_no_done", 32'(nd), 32'd0);
    sb.push_back(mk("restart", 16'h00C0, 16'h0041, 16'h0040, 16'h0040, 16'h0040, 16'h0040));
    run("restart", 0, 8'd1, 1'b1, 1'b0, 10, 11);
    pop_check(0);

    // DP=4, 3 epochs, with a write and a start attempted mid-run.
    for (int s = 0; s < 4; s++) load(1, s, smp[s]);
    sb.push_back(model("dp4_e3", 3));
    run("dp4_e3", 1, 8'd3, 1'b1, 1'b1, 120, 121);
    pop_check(1);
    // The blocked write must not have reached the RAM.
    sb.push_back(model("dp4_e1", 1));
    run("dp4_e1", 1, 8'd1, 1'b1, 1'b0, 40, 41);
    pop_check(1);

    // Large weights and features: saturation versus wrap-around.
    load(2, 0, {16'h0000, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00});
`ifdef SGD_SATURATE_EN
    sb.push_back(mk("big", 16'h8001, 16'h7E00, 16'h0000, 16'h0000, 16'h0000, 16'h0000));
`else
    sb.push_back(mk("big", 16'h7D00, 16'h7FFA, 16'hFB06, 16'hFB06, 16'hFB06, 16'hFB06));
`endif
    run("big", 2, 8'd1, 1'b1, 1'b0, 10, 11);
    pop_check(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
